// File: rtl/gpio_display.sv
// gpio_display: sink for the CPU GPIO output word, shown on an 8-digit
// multiplexed, active-low seven-segment display in hex or in decimal.
// The decimal path uses a serial double-dabble converter, one bit per clock.
//   clk, reset_n  : clock, asynchronous active-low reset
//   gpio_out_i    : 32-bit word written by the CPU
//   gpio_we_i     : one-cycle write strobe for gpio_out_i
//   dec_mode_i    : 0 = hex, 1 = decimal (sampled with gpio_we_i)
//   busy_o        : decimal conversion in progress
//   seg_o         : segments a..g on bits 0..6, active low
//   an_o          : one-hot active-low digit enable, bit0 = rightmost digit
module gpio_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] gpio_out_i,
   input  logic        gpio_we_i,
   input  logic        dec_mode_i,
   output logic        busy_o,
   output logic [6:0]  seg_o,
   output logic [7:0]  an_o
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t      state;
   logic [31:0] disp;        // eight nibbles, nibble i drives digit i
   logic [7:0]  blank;       // per-digit leading-zero blank
   logic        dash;        // decimal overflow: every digit shows "-"
   logic [31:0] shift;
   logic [39:0] bcd;
   logic [4:0]  cnt;
   logic [CW-1:0] scan_cnt;
   logic [2:0]  idx;

   // One double-dabble step: correct each BCD digit, then shift {bcd,shift}.
   logic [39:0] bcd_adj;
   logic [39:0] bcd_next;
   logic [7:0]  blank_next;
   logic        nz;

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 10; i++)
         bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                                     : bcd[i*4 +: 4];
      bcd_next = {bcd_adj[38:0], shift[31]};
      // Blank every digit above the most significant nonzero one; digit 0
      // is never blanked so a zero result still shows "0".
      blank_next = '0;
      nz         = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         nz            = nz | (bcd_next[i*4 +: 4] != 4'd0);
         blank_next[i] = ~nz;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         busy_o <= 1'b0;
         disp   <= '0;
         blank  <= '0;
         dash   <= 1'b0;
         shift  <= '0;
         bcd    <= '0;
         cnt    <= '0;
      end else if (gpio_we_i) begin
         // A write in any state wins over a running conversion.
         if (dec_mode_i) begin
            shift  <= gpio_out_i;
            bcd    <= '0;
            cnt    <= '0;
            state  <= CONVERT;
            busy_o <= 1'b1;
         end else begin
            disp   <= gpio_out_i;
            blank  <= '0;
            dash   <= 1'b0;
            state  <= IDLE;
            busy_o <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: busy_o <= 1'b0;
            CONVERT: begin
               bcd   <= bcd_next;
               shift <= {shift[30:0], 1'b0};
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  disp   <= bcd_next[31:0];
                  blank  <= blank_next;
                  dash   <= (bcd_next[39:32] != 8'd0);
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Free-running digit scan; an_o is registered alongside the digit index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         an_o     <= 8'b1111_1110;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
         an_o     <= ~(8'b1 << (idx + 3'd1));
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   logic [3:0] nib;

   always_comb begin
      nib = disp[{idx, 2'b00} +: 4];
      if (dash)
         seg_o = 7'b011_1111;
      else if (blank[idx])
         seg_o = 7'b111_1111;
      else begin
         case (nib)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            default: seg_o = 7'h0E;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_display.sv
// Self-checking bench for gpio_display with a fast scan (SCAN_DIV = 4).
// Expected glyphs come from a reference model that converts with plain
// integer division/modulo rather than the shift-and-add algorithm.
module tb_gpio_display;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] gpio_out_i;
   logic        gpio_we_i;
   logic        dec_mode_i;
   logic        busy_o;
   logic [6:0]  seg_o;
   logic [7:0]  an_o;

   int vectors = 0;
   int miscompares = 0;

   gpio_display #(.SCAN_DIV(4)) dut (
      .clk(clk), .reset_n(reset_n), .gpio_out_i(gpio_out_i),
      .gpio_we_i(gpio_we_i), .dec_mode_i(dec_mode_i), .busy_o(busy_o),
      .seg_o(seg_o), .an_o(an_o)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
         4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
         4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // Expected glyph per digit for a word shown in hex or decimal.
   function automatic logic [7:0][6:0] model(input logic [31:0] v, input logic d);
      logic [7:0][6:0] m;
      longint p;
      longint lv;
      lv = longint'(v);
      p  = 1;
      for (int i = 0; i < 8; i++) begin
         if (!d)
            m[i] = glyph(v[i*4 +: 4]);
         else if (lv > 64'd99999999)
            m[i] = 7'h3F;
         else if (i > 0 && lv < p)
            m[i] = 7'h7F;
         else
            m[i] = glyph(4'((lv / p) % 10));
         p = p * 10;
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Drive one write; returns just after its sampling edge (E0).
   task automatic wr(input logic [31:0] v, input logic d);
      gpio_out_i = v;
      dec_mode_i = d;
      gpio_we_i  = 1'b1;
      step();
      gpio_we_i  = 1'b0;
   endtask

   // Watch the scan until every digit has been seen once, checking each.
   task automatic check_disp(input logic [7:0][6:0] exp, input string tag);
      logic [7:0] seen;
      int         sel;
      seen = '0;
      for (int c = 0; c < 48 && seen != 8'hFF; c++) begin
         sel = -1;
         for (int i = 0; i < 8; i++)
            if (an_o === ~(8'b1 << i)) sel = i;
         if (sel < 0) begin
            chk({tag, " an_onehot"}, {24'd0, an_o}, 32'hFE);
         end else if (!seen[sel]) begin
            seen[sel] = 1'b1;
            chk($sformatf("%s digit%0d", tag, sel), {25'd0, seg_o}, {25'd0, exp[sel]});
         end
         step();
      end
      chk({tag, " scan_complete"}, {24'd0, seen}, 32'hFF);
   endtask

   // Decimal write with busy timing checks: high after E0 and E31, low after E32.
   task automatic dec_run(input logic [31:0] v, input string tag);
      wr(v, 1'b1);
      chk({tag, " busy_E0"}, {31'd0, busy_o}, 32'd1);
      repeat (31) step();
      chk({tag, " busy_E31"}, {31'd0, busy_o}, 32'd1);
      step();
      chk({tag, " busy_E32"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      logic        d;
      reset_n    = 1'b0;
      gpio_we_i  = 1'b0;
      gpio_out_i = '0;
      dec_mode_i = 1'b0;
      #12;
      chk("rst an", {24'd0, an_o}, 32'hFE);
      chk("rst seg", {25'd0, seg_o}, 32'h40);
      chk("rst busy", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Scan stepping: one digit every 4 clocks, wrapping 7 -> 0.
      for (int s = 0; s < 36; s++) begin
         chk($sformatf("scan an s%0d", s), {24'd0, an_o}, {24'd0, ~(8'b1 << ((s / 4) % 8))});
         chk($sformatf("scan seg s%0d", s), {25'd0, seg_o}, 32'h40);
         step();
      end

      wr(32'h1234ABCD, 1'b0);
      chk("hex busy", {31'd0, busy_o}, 32'd0);
      check_disp(model(32'h1234ABCD, 1'b0), "hex1234ABCD");

      dec_run(32'd12345, "dec12345");
      check_disp(model(32'd12345, 1'b1), "dec12345");

      dec_run(32'd100000000, "dec_ovf");
      check_disp(model(32'd100000000, 1'b1), "dec_ovf");
      dec_run(32'd99999999, "dec_max");
      check_disp(model(32'd99999999, 1'b1), "dec_max");
      dec_run(32'hFFFFFFFF, "dec_allones");
      check_disp(model(32'hFFFFFFFF, 1'b1), "dec_allones");

      // Restart: decimal 7, then decimal 0 sampled at E10.
      wr(32'd7, 1'b1);
      repeat (9) step();
      wr(32'd0, 1'b1);
      chk("restart busy_E10", {31'd0, busy_o}, 32'd1);
      repeat (31) step();
      chk("restart busy_E41", {31'd0, busy_o}, 32'd1);
      step();
      chk("restart busy_E42", {31'd0, busy_o}, 32'd0);
      check_disp(model(32'd0, 1'b1), "restart_zero");

      // Hex write aborts a running conversion.
      wr(32'd12345678, 1'b1);
      repeat (5) step();
      wr(32'h5, 1'b0);
      chk("abort busy", {31'd0, busy_o}, 32'd0);
      check_disp(model(32'h5, 1'b0), "abort_hex5");

      // Reset in the middle of a conversion.
      wr(32'd42, 1'b1);
      repeat (14) step();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst busy", {31'd0, busy_o}, 32'd0);
      chk("midrst an", {24'd0, an_o}, 32'hFE);
      step();
      reset_n = 1'b1;
      check_disp(model(32'd0, 1'b0), "midrst_disp");

      // Randomized writes of varied magnitude in both modes.
      for (int k = 0; k < 24; k++) begin
         v = $urandom() >> $urandom_range(0, 31);
         d = 1'($urandom_range(0, 1));
         if (d) begin
            dec_run(v, $sformatf("rnd%0d", k));
         end else begin
            wr(v, 1'b0);
            chk($sformatf("rnd%0d busy", k), {31'd0, busy_o}, 32'd0);
         end
         check_disp(model(v, d), $sformatf("rnd%0d_%0h", k, v));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
